// File: rtl/mdr_mem_port_if.sv
// Memory-side handshake bundle for the MDR/MAR port.
// master drives address/data/strobes; slave is the external memory.
interface mdr_mem_port_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mdr_mem_port.sv
// MAR/MDR registers with a single-word handshaked memory port.
// Each transaction ends in a one-cycle done pulse; an ack timeout sets sticky err.
//
// state   | meaning
// IDLE    | accepts MAR/MDR loads and rd/wr requests
// RD_WAIT | mem_rd held, waiting for mem_ack or timeout
// WR_WAIT | mem_wr held, waiting for mem_ack or timeout
// DONE    | done pulse, strobes low, back to IDLE next edge
module mdr_mem_port #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [31:0]          bus_in,
  input  logic                 MARin,
  input  logic                 MDRin,
  input  logic                 rd_req,
  input  logic                 wr_req,
  output logic [31:0]          mdr_out,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  mdr_mem_port_if.master       mem
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] mar;
  logic [31:0]       mdr;
  logic [7:0]        wait_cnt;
  logic              rd_q;
  logic              wr_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      mar      <= '0;
      mdr      <= '0;
      wait_cnt <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (MARin) mar <= bus_in[ADDR_W-1:0];
          if (MDRin) mdr <= bus_in;
          // read has priority when both requests arrive together
          if (rd_req) begin
            state    <= RD_WAIT;
            rd_q     <= 1'b1;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
            wait_cnt <= '0;
          end else if (wr_req) begin
            state    <= WR_WAIT;
            wr_q     <= 1'b1;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
            wait_cnt <= '0;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem.mem_ack) begin
            if (state == RD_WAIT) mdr <= mem.mem_rdata;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else if (wait_cnt == CNT_LAST) begin
            err_q  <= 1'b1;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mdr_out       = mdr;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign mem.mem_addr  = mar;
  assign mem.mem_wdata = mdr;
  assign mem.mem_rd    = rd_q;
  assign mem.mem_wr    = wr_q;

endmodule
